// File: rtl/valve_driver.sv
// valve_driver
//   Actuator side of the irrigation controller. Qualifies the per-zone valve
//   commands, then drives four solenoid coils through an inrush (PULL),
//   PWM hold (HOLD) and enforced minimum-off (COOLDOWN) profile.
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high reset
//   R1     zone-1 command: bit0 = valve 0, bit1 = valve 1
//   R2     zone-2 command: bit0 = valve 2, bit1 = valve 3
//   E      controller error code, 00 = no error
//   coil   registered coil drive, one bit per valve
//   open   registered, 1 = valve in PULL or HOLD
//   fault  registered copy of (E != 00)
//   busy   registered, 1 = any valve in PULL or COOLDOWN
module valve_driver #(
  parameter int STABLE_CYC  = 4,
  parameter int PULL_CYC    = 16,
  parameter int PWM_PERIOD  = 8,
  parameter int PWM_HIGH    = 3,
  parameter int MIN_OFF_CYC = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] R1,
  input  logic [1:0] R2,
  input  logic [1:0] E,
  output logic [3:0] coil,
  output logic [3:0] open,
  output logic       fault,
  output logic       busy
);

  localparam int TMR_MAX = (PULL_CYC > MIN_OFF_CYC) ? PULL_CYC : MIN_OFF_CYC;
  localparam int TW      = (TMR_MAX > 2) ? $clog2(TMR_MAX) : 1;
  localparam int SW      = $clog2(STABLE_CYC + 1);
  localparam int PW      = (PWM_PERIOD > 2) ? $clog2(PWM_PERIOD) : 1;

  localparam logic [TW-1:0] PULL_LAST = TW'(PULL_CYC - 1);
  localparam logic [TW-1:0] OFF_LAST  = TW'(MIN_OFF_CYC - 1);
  localparam logic [SW-1:0] STAB_MAX  = SW'(STABLE_CYC);
  localparam logic [PW-1:0] PWM_LAST  = PW'(PWM_PERIOD - 1);
  localparam logic [PW-1:0] PWM_HI    = PW'(PWM_HIGH);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_PULL = 2'd1,
    ST_HOLD = 2'd2,
    ST_COOL = 2'd3
  } state_t;

  state_t          state_q [4];
  state_t          state_d [4];
  logic [TW-1:0]   timer_q [4];
  logic [TW-1:0]   timer_d [4];
  logic [3:0]      t_q, t_d;
  logic [SW-1:0]   stab_q, stab_d;
  logic [3:0]      cmd_q, cmd_d;
  logic [PW-1:0]   pwm_q, pwm_d;
  logic [3:0]      coil_q, coil_d;
  logic [3:0]      open_q, open_d;
  logic            fault_q, fault_d;
  logic            busy_q, busy_d;

  logic            err_s;
  logic [3:0]      t_s;
  logic [3:0]      req_s;
  logic [3:0]      pull_keep_s;
  logic [3:0]      grant_s;
  logic            lower_s;

  // Next-state logic: command qualifier, inrush arbitration, valve FSMs, outputs.
  always_comb begin
    err_s = (E != 2'b00);
    t_s   = err_s ? 4'b0000 : {R2, R1};
    t_d   = t_s;

    if (t_s != t_q) begin
      stab_d = {SW{1'b0}};
    end else if (stab_q == STAB_MAX) begin
      stab_d = stab_q;
    end else begin
      stab_d = stab_q + SW'(1);
    end

    // An error clears the command at once; otherwise only a settled target is taken.
    if (err_s) begin
      cmd_d = 4'b0000;
    end else if (stab_d == STAB_MAX) begin
      cmd_d = t_s;
    end else begin
      cmd_d = cmd_q;
    end

    if (pwm_q == PWM_LAST) begin
      pwm_d = {PW{1'b0}};
    end else begin
      pwm_d = pwm_q + PW'(1);
    end

    // A valve that is leaving PULL this edge frees the inrush slot for another.
    for (int i = 0; i < 4; i++) begin
      req_s[i]       = (state_q[i] == ST_OFF) && cmd_q[i];
      pull_keep_s[i] = (state_q[i] == ST_PULL) && cmd_q[i] && (timer_q[i] != PULL_LAST);
    end

    // Lowest-index requester wins the single inrush slot.
    lower_s = 1'b0;
    for (int i = 0; i < 4; i++) begin
      grant_s[i] = req_s[i] && !lower_s && !(|pull_keep_s);
      lower_s    = lower_s | req_s[i];
    end

    for (int i = 0; i < 4; i++) begin
      state_d[i] = state_q[i];
      timer_d[i] = timer_q[i];
      case (state_q[i])
        ST_OFF: begin
          if (grant_s[i]) begin
            state_d[i] = ST_PULL;
            timer_d[i] = {TW{1'b0}};
          end else begin
            state_d[i] = ST_OFF;
          end
        end
        ST_PULL: begin
          // Dropped command beats the inrush timeout.
          if (!cmd_q[i]) begin
            state_d[i] = ST_COOL;
            timer_d[i] = {TW{1'b0}};
          end else if (timer_q[i] == PULL_LAST) begin
            state_d[i] = ST_HOLD;
            timer_d[i] = {TW{1'b0}};
          end else begin
            timer_d[i] = timer_q[i] + TW'(1);
          end
        end
        ST_HOLD: begin
          if (!cmd_q[i]) begin
            state_d[i] = ST_COOL;
            timer_d[i] = {TW{1'b0}};
          end else begin
            state_d[i] = ST_HOLD;
          end
        end
        ST_COOL: begin
          if (timer_q[i] == OFF_LAST) begin
            state_d[i] = ST_OFF;
            timer_d[i] = {TW{1'b0}};
          end else begin
            timer_d[i] = timer_q[i] + TW'(1);
          end
        end
        default: begin
          state_d[i] = ST_OFF;
          timer_d[i] = {TW{1'b0}};
        end
      endcase
    end

    // Outputs are derived from the next state so they line up with it in time.
    busy_d = 1'b0;
    for (int i = 0; i < 4; i++) begin
      coil_d[i] = (state_d[i] == ST_PULL) || ((state_d[i] == ST_HOLD) && (pwm_d < PWM_HI));
      open_d[i] = (state_d[i] == ST_PULL) || (state_d[i] == ST_HOLD);
      busy_d    = busy_d || (state_d[i] == ST_PULL) || (state_d[i] == ST_COOL);
    end
    fault_d = err_s;
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      t_q     <= 4'b0000;
      stab_q  <= {SW{1'b0}};
      cmd_q   <= 4'b0000;
      pwm_q   <= {PW{1'b0}};
      coil_q  <= 4'b0000;
      open_q  <= 4'b0000;
      fault_q <= 1'b0;
      busy_q  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= ST_OFF;
        timer_q[i] <= {TW{1'b0}};
      end
    end else begin
      t_q     <= t_d;
      stab_q  <= stab_d;
      cmd_q   <= cmd_d;
      pwm_q   <= pwm_d;
      coil_q  <= coil_d;
      open_q  <= open_d;
      fault_q <= fault_d;
      busy_q  <= busy_d;
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= state_d[i];
        timer_q[i] <= timer_d[i];
      end
    end
  end

  assign coil  = coil_q;
  assign open  = open_q;
  assign fault = fault_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_valve_driver.sv
// tb_valve_driver
//   Directed self-checking bench for valve_driver. Edge k is the k-th rising
//   clock edge after reset is released; outputs are sampled 1 time unit
//   after that edge. Expected values are written from the drive profile:
//   valve whose PULL starts at edge s has coil=1 for edges s..s+15, then the
//   hold pattern, high when ((k+1) mod 8) < 3 (shared PWM counter from reset).
module tb_valve_driver;

  logic       clk;
  logic       reset;
  logic [1:0] R1;
  logic [1:0] R2;
  logic [1:0] E;
  logic [3:0] coil;
  logic [3:0] open;
  logic       fault;
  logic       busy;

  int checks;
  int errors;

  valve_driver dut (
    .clk   (clk),
    .reset (reset),
    .R1    (R1),
    .R2    (R2),
    .E     (E),
    .coil  (coil),
    .open  (open),
    .fault (fault),
    .busy  (busy)
  );

  // 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic hold_at(int k);
    return ((k + 1) % 8) < 3;
  endfunction

  // Expected coil bit for a valve entering PULL at edge s and staying open.
  function automatic logic coil_at(int k, int s);
    if (k < s) return 1'b0;
    if (k < s + 16) return 1'b1;
    return hold_at(k);
  endfunction

  task automatic rst(input logic [1:0] r1, input logic [1:0] r2, input logic [1:0] e);
    @(negedge clk);
    reset = 1'b1;
    R1 = r1;
    R2 = r2;
    E  = e;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({coil, open, fault, busy} !== 10'b0) begin
      errors++;
      $display("FAIL reset_outputs got=%b exp=%b", {coil, open, fault, busy}, 10'b0);
    end
  endtask

  task automatic test_single_open();
    logic [3:0] ec;
    rst(2'b01, 2'b00, 2'b00);
    for (int k = 0; k <= 40; k++) begin
      @(posedge clk); #1;
      ec = {3'b000, coil_at(k, 5)};
      checks++;
      if (coil !== ec) begin
        errors++;
        $display("FAIL single_coil k=%0d got=%b exp=%b", k, coil, ec);
      end
      checks++;
      if (open !== {3'b000, (k >= 5)}) begin
        errors++;
        $display("FAIL single_open k=%0d got=%b exp=%b", k, open, {3'b000, (k >= 5)});
      end
      checks++;
      if (busy !== (k >= 5 && k <= 20) || fault !== 1'b0) begin
        errors++;
        $display("FAIL single_busy k=%0d got=%b%b exp=%b0", k, busy, fault, (k >= 5 && k <= 20));
      end
    end
  endtask

  task automatic test_glitch();
    rst(2'b01, 2'b00, 2'b00);
    for (int k = 0; k <= 20; k++) begin
      if (k == 3) R1 = 2'b00;
      if (k == 6) R1 = 2'b01;
      if (k == 9) R1 = 2'b00;
      @(posedge clk); #1;
      checks++;
      if (coil !== 4'b0000 || open !== 4'b0000) begin
        errors++;
        $display("FAIL glitch k=%0d got=%b/%b exp=0000/0000", k, coil, open);
      end
    end
  endtask

  task automatic test_arbitration();
    logic [3:0] ec;
    logic [3:0] eo;
    rst(2'b11, 2'b11, 2'b00);
    for (int k = 0; k <= 75; k++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
        ec[i] = coil_at(k, 5 + 16 * i);
        eo[i] = (k >= 5 + 16 * i);
      end
      checks++;
      if (coil !== ec || open !== eo) begin
        errors++;
        $display("FAIL arb k=%0d got=%b/%b exp=%b/%b", k, coil, open, ec, eo);
      end
      checks++;
      if (busy !== (k >= 5 && k < 69)) begin
        errors++;
        $display("FAIL arb_busy k=%0d got=%b exp=%b", k, busy, (k >= 5 && k < 69));
      end
    end
  endtask

  task automatic test_error_override();
    logic [3:0] ec;
    logic [3:0] eo;
    logic       eb;
    rst(2'b11, 2'b11, 2'b00);
    for (int k = 0; k <= 110; k++) begin
      if (k == 76) E = 2'b11;
      if (k == 78) E = 2'b00;
      @(posedge clk); #1;
      if (k >= 76) begin
        if (k == 76) begin
          ec = {4{hold_at(k)}};
          eo = 4'b1111;
          eb = 1'b0;
        end else if (k < 110) begin
          ec = 4'b0000;
          eo = 4'b0000;
          eb = (k <= 108);
        end else begin
          ec = 4'b0001;
          eo = 4'b0001;
          eb = 1'b1;
        end
        checks++;
        if (coil !== ec || open !== eo || busy !== eb) begin
          errors++;
          $display("FAIL err k=%0d got=%b/%b/%b exp=%b/%b/%b", k, coil, open, busy, ec, eo, eb);
        end
        checks++;
        if (fault !== (k <= 77)) begin
          errors++;
          $display("FAIL err_fault k=%0d got=%b exp=%b", k, fault, (k <= 77));
        end
      end
    end
  endtask

  task automatic test_min_off();
    logic ec;
    logic eo;
    logic eb;
    rst(2'b01, 2'b00, 2'b00);
    for (int k = 0; k <= 70; k++) begin
      if (k == 30) R1 = 2'b00;
      if (k == 45) R1 = 2'b01;
      @(posedge clk); #1;
      if (k < 35) ec = coil_at(k, 5);
      else if (k < 68) ec = 1'b0;
      else ec = 1'b1;
      eo = (k >= 5 && k <= 34) || (k >= 68);
      eb = (k >= 5 && k <= 20) || (k >= 35 && k <= 66) || (k >= 68);
      checks++;
      if (coil !== {3'b000, ec} || open !== {3'b000, eo} || busy !== eb) begin
        errors++;
        $display("FAIL min_off k=%0d got=%b/%b/%b exp=%b/%b/%b", k, coil, open, busy, ec, eo, eb);
      end
    end
  endtask

  task automatic test_drop_at_timeout();
    logic ea;
    rst(2'b01, 2'b00, 2'b00);
    for (int k = 0; k <= 24; k++) begin
      if (k == 16) R1 = 2'b00;
      @(posedge clk); #1;
      ea = (k >= 5 && k <= 20);
      checks++;
      if (coil !== {3'b000, ea} || open !== {3'b000, ea} || busy !== (k >= 5)) begin
        errors++;
        $display("FAIL drop_timeout k=%0d got=%b/%b/%b exp=%b/%b/%b", k, coil, open, busy,
                 {3'b000, ea}, {3'b000, ea}, (k >= 5));
      end
    end
  endtask

  task automatic test_error_vs_cmd();
    rst(2'b01, 2'b00, 2'b00);
    for (int k = 0; k <= 12; k++) begin
      if (k == 4) E = 2'b11;
      @(posedge clk); #1;
      checks++;
      if (coil !== 4'b0000 || open !== 4'b0000 || fault !== (k >= 4)) begin
        errors++;
        $display("FAIL err_vs_cmd k=%0d got=%b/%b/%b exp=0000/0000/%b", k, coil, open, fault, (k >= 4));
      end
    end
    E = 2'b00;
  endtask

  task automatic test_async_reset();
    rst(2'b00, 2'b01, 2'b00);
    for (int k = 0; k <= 8; k++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (coil !== 4'b0100) begin
      errors++;
      $display("FAIL async_pre got=%b exp=%b", coil, 4'b0100);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (coil !== 4'b0000 || open !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL async_drop got=%b/%b/%b exp=0000/0000/0", coil, open, busy);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      @(posedge clk); #1;
      checks++;
      if (coil !== ((k >= 5) ? 4'b0100 : 4'b0000)) begin
        errors++;
        $display("FAIL async_reopen k=%0d got=%b exp=%b", k, coil, (k >= 5) ? 4'b0100 : 4'b0000);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    R1     = 2'b00;
    R2     = 2'b00;
    E      = 2'b00;
    test_reset();
    test_single_open();
    test_glitch();
    test_arbitration();
    test_error_override();
    test_min_off();
    test_drop_at_timeout();
    test_error_vs_cmd();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
